// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 3-stage pipelined core. Owns the program
// counter, presents it to instruction memory, and registers the returned word
// and its PC into the IF/ID pipeline register consumed by decode.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   stall        in   1      hold PC and IF/ID register this cycle
//   redirect     in   1      load PC from redirect_pc, squash IF/ID slot
//   redirect_pc  in   ISIZE  redirect target
//   imem_addr    out  ISIZE  instruction-memory address (= current PC)
//   imem_data    in   DSIZE  instruction word at imem_addr (combinational)
//   inst_out     out  DSIZE  IF/ID instruction (0 = bubble)
//   pc_out       out  ISIZE  IF/ID PC of inst_out
//   valid_out    out  1      IF/ID slot holds a real instruction
//   halted       out  1      fetch FSM is in HALTED
//   fetch_count  out  16     valid instructions captured, saturating
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int              ISIZE    = 16,
    parameter int              DSIZE    = 16,
    parameter logic [ISIZE-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [DSIZE-1:0] imem_data,
    output logic [DSIZE-1:0] inst_out,
    output logic [ISIZE-1:0] pc_out,
    output logic             valid_out,
    output logic             halted,
    output logic [15:0]      fetch_count
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]       state;
    logic [ISIZE-1:0] pc;
    logic             is_halt_op;

    // Opcode lives in the top nibble of the instruction word.
    assign is_halt_op = (imem_data[DSIZE-1 -: 4] == HALT_OP);

    // Memory always sees the live PC, even while stalled or halted.
    assign imem_addr = pc;

    // halted comes straight off the state flop, so it is a registered output.
    assign halted = (state == HALTED);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates on an edge see the pre-edge values of each other (pc_out
    // captures the old pc while pc advances).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inst_out    <= '0;
            pc_out      <= '0;
            valid_out   <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Redirect overrides stall and leaves HALTED; the squashed slot
            // becomes a bubble and the target is fetched on the next edge.
            state     <= RUN;
            pc        <= redirect_pc;
            inst_out  <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else if (stall) begin
            // Everything holds; no assignments needed.
        end else if (state == RUN) begin
            inst_out  <= imem_data;
            pc_out    <= pc;
            valid_out <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (is_halt_op) begin
                // PC stays on the HALT word so a debugger sees where fetch stopped.
                state <= HALTED;
            end else begin
                pc <= pc + ISIZE'(1);
            end
        end else begin
            // HALTED: keep feeding bubbles downstream.
            inst_out  <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed testbench for if_fetch_stage. A behavioural instruction memory
// answers imem_addr combinationally. Inputs change and outputs are sampled on
// the falling clock edge, away from the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    if_fetch_stage #(
        .ISIZE    (16),
        .DSIZE    (16),
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    // Redirect issued for one edge, then released.
    task automatic do_redirect(input logic [15:0] target, input logic with_stall);
        redirect    = 1'b1;
        redirect_pc = target;
        stall       = with_stall;
        @(negedge clk);
        redirect = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #1;
        n_cmp++;
        if ({pc_out, inst_out, valid_out, halted, fetch_count, imem_addr} !== {16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_state: got pc_out=%h inst=%h v=%b h=%b cnt=%0d addr=%h, want all zero",
                     pc_out, inst_out, valid_out, halted, fetch_count, imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        logic [15:0] exp_inst [4];
        exp_inst[0] = 16'h1123;
        exp_inst[1] = 16'h2234;
        exp_inst[2] = 16'h3345;
        exp_inst[3] = 16'h4456;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({pc_out, inst_out, valid_out} !== {16'(i), exp_inst[i], 1'b1}) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got (%h,%h,%b), want (%h,%h,1)",
                         i, pc_out, inst_out, valid_out, 16'(i), exp_inst[i]);
            end
        end
        n_cmp++;
        if (fetch_count !== 16'd4) begin
            n_err++;
            $display("FAIL seq_count: got %0d, want 4", fetch_count);
        end
    endtask

    task automatic test_stall;
        // Restart at 0: bubble, capture pc0, capture pc1 (inst 2234). Count 4 -> 6.
        do_redirect(16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({inst_out, pc_out, imem_addr, valid_out, fetch_count} !== {16'h2234, 16'h1, 16'h2, 1'b1, 16'd6}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got inst=%h pc_out=%h addr=%h v=%b cnt=%0d, want 2234/1/2/1/6",
                         i, inst_out, pc_out, imem_addr, valid_out, fetch_count);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pc_out, inst_out, fetch_count} !== {16'h2, 16'h3345, 16'd7}) begin
            n_err++;
            $display("FAIL stall_release: got pc_out=%h inst=%h cnt=%0d, want 2/3345/7",
                     pc_out, inst_out, fetch_count);
        end
    endtask

    task automatic test_redirect_stall;
        // Capture pc3 and pc4 so pc = 5, count = 9.
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({imem_addr, fetch_count} !== {16'h5, 16'd9}) begin
            n_err++;
            $display("FAIL redir_setup: got addr=%h cnt=%0d, want 5/9", imem_addr, fetch_count);
        end
        do_redirect(16'h0040, 1'b1);
        n_cmp++;
        if ({valid_out, inst_out, pc_out, imem_addr, fetch_count} !== {1'b0, 16'h0, 16'h0, 16'h0040, 16'd9}) begin
            n_err++;
            $display("FAIL redir_bubble: got v=%b inst=%h pc_out=%h addr=%h cnt=%0d, want 0/0/0/0040/9",
                     valid_out, inst_out, pc_out, imem_addr, fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({pc_out, inst_out, valid_out, fetch_count} !== {16'h0040, 16'h1040, 1'b1, 16'd10}) begin
            n_err++;
            $display("FAIL redir_target: got pc_out=%h inst=%h v=%b cnt=%0d, want 0040/1040/1/10",
                     pc_out, inst_out, valid_out, fetch_count);
        end
    endtask

    task automatic test_halt_resume;
        mem[2] = 16'hF000;
        do_redirect(16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // HALT word captured on the last edge; state already HALTED.
        n_cmp++;
        if ({pc_out, inst_out, valid_out, halted, imem_addr, fetch_count} !== {16'h2, 16'hF000, 1'b1, 1'b1, 16'h2, 16'd13}) begin
            n_err++;
            $display("FAIL halt_capture: got pc_out=%h inst=%h v=%b h=%b addr=%h cnt=%0d, want 2/F000/1/1/2/13",
                     pc_out, inst_out, valid_out, halted, imem_addr, fetch_count);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({halted, valid_out, inst_out, pc_out, imem_addr, fetch_count} !== {1'b1, 1'b0, 16'h0, 16'h0, 16'h2, 16'd13}) begin
                n_err++;
                $display("FAIL halt_hold[%0d]: got h=%b v=%b inst=%h pc_out=%h addr=%h cnt=%0d, want 1/0/0/0/2/13",
                         i, halted, valid_out, inst_out, pc_out, imem_addr, fetch_count);
            end
        end
        do_redirect(16'h0000, 1'b0);
        n_cmp++;
        if ({halted, valid_out, imem_addr} !== {1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL halt_exit: got h=%b v=%b addr=%h, want 0/0/0", halted, valid_out, imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({pc_out, inst_out, valid_out, fetch_count} !== {16'h0, 16'h1123, 1'b1, 16'd14}) begin
            n_err++;
            $display("FAIL halt_resume: got pc_out=%h inst=%h v=%b cnt=%0d, want 0/1123/1/14",
                     pc_out, inst_out, valid_out, fetch_count);
        end
    endtask

    task automatic test_pc_wrap;
        logic [15:0] exp_pc   [4];
        logic [15:0] exp_inst [4];
        exp_pc[0] = 16'hFFFE; exp_inst[0] = 16'h1FFE;
        exp_pc[1] = 16'hFFFF; exp_inst[1] = 16'h1FFF;
        exp_pc[2] = 16'h0000; exp_inst[2] = 16'h1123;
        exp_pc[3] = 16'h0001; exp_inst[3] = 16'h2234;
        do_redirect(16'hFFFE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({pc_out, inst_out, valid_out} !== {exp_pc[i], exp_inst[i], 1'b1}) begin
                n_err++;
                $display("FAIL pc_wrap[%0d]: got (%h,%h,%b), want (%h,%h,1)",
                         i, pc_out, inst_out, valid_out, exp_pc[i], exp_inst[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        // Fresh start, HALT placed at 6 so seven words are captured.
        mem[2] = 16'h3345;
        mem[6] = 16'hF000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({halted, fetch_count, imem_addr} !== {1'b1, 16'd7, 16'h6}) begin
            n_err++;
            $display("FAIL areset_setup: got h=%b cnt=%0d addr=%h, want 1/7/6", halted, fetch_count, imem_addr);
        end
        // Assert reset mid-cycle; next rising edge is 5 time units away.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pc_out, inst_out, valid_out, halted, fetch_count, imem_addr} !== {16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL areset_immediate: got pc_out=%h inst=%h v=%b h=%b cnt=%0d addr=%h, want all zero",
                     pc_out, inst_out, valid_out, halted, fetch_count, imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pc_out, inst_out, valid_out, fetch_count} !== {16'h0, 16'h1123, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL areset_restart: got pc_out=%h inst=%h v=%b cnt=%0d, want 0/1123/1/1",
                     pc_out, inst_out, valid_out, fetch_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'h1000 | (16'(i) & 16'h0FFF);
        end
        mem[0] = 16'h1123;
        mem[1] = 16'h2234;
        mem[2] = 16'h3345;
        mem[3] = 16'h4456;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt_resume();
        test_pc_wrap();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
